// File: rtl/seq_divider.sv
// Iterative restoring divider for RV32 DIV/DIVU/REM/REMU.
// One shift-and-subtract step per cycle for N cycles, then one sign-fix cycle.
module seq_divider #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic                load, step, finish;
   logic [CW-1:0]       cnt;
   logic [N:0]          r;
   logic [N-1:0]        q;
   logic [N-1:0]        dvs_mag;
   logic [N-1:0]        dvd_raw;
   logic                rem_sel, qneg, rneg, dbz, ovf;
   logic [N+1:0]        r_sh;
   logic signed [N+1:0] trial;

   function automatic logic [N-1:0] neg(input logic [N-1:0] v);
      return (~v) + {{(N-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic is_signed);
      return (is_signed && v[N-1]) ? neg(v) : v;
   endfunction

   // Special cases take priority over the iterated quotient/remainder.
   function automatic logic [N-1:0] fix_result(
      input logic         sel_rem,
      input logic         f_dbz,
      input logic         f_ovf,
      input logic         f_qneg,
      input logic         f_rneg,
      input logic [N-1:0] qv,
      input logic [N-1:0] rv,
      input logic [N-1:0] dvd
   );
      if (f_dbz)
         return sel_rem ? dvd : {N{1'b1}};
      if (f_ovf)
         return sel_rem ? {N{1'b0}} : MIN_NEG;
      if (sel_rem)
         return f_rneg ? neg(rv) : rv;
      return f_qneg ? neg(qv) : qv;
   endfunction

   // One extra guard bit keeps the trial subtraction sign-correct for any divisor.
   assign r_sh  = {r, q[N-1]};
   assign trial = $signed(r_sh) - $signed({2'b00, dvs_mag});

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ITER;
         ITER:    if (cnt == LAST) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load   = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      case (state)
         IDLE:    load   = start;
         ITER:    step   = 1'b1;
         FIX:     finish = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         cnt     <= '0;
         r       <= '0;
         q       <= '0;
         dvs_mag <= '0;
         dvd_raw <= '0;
         rem_sel <= 1'b0;
         qneg    <= 1'b0;
         rneg    <= 1'b0;
         dbz     <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            busy    <= 1'b1;
            rem_sel <= op[1];
            dvd_raw <= dividend;
            dvs_mag <= mag(divisor, !op[0]);
            q       <= mag(dividend, !op[0]);
            r       <= '0;
            cnt     <= '0;
            qneg    <= !op[0] && (dividend[N-1] ^ divisor[N-1]);
            rneg    <= !op[0] && dividend[N-1];
            dbz     <= (divisor == '0);
            ovf     <= !op[0] && (dividend == MIN_NEG) && (divisor == {N{1'b1}});
         end else if (step) begin
            cnt <= cnt + CW'(1);
            if (!trial[N+1]) begin
               r <= trial[N:0];
               q <= {q[N-2:0], 1'b1};
            end else begin
               r <= r_sh[N:0];
               q <= {q[N-2:0], 1'b0};
            end
         end else if (finish) begin
            result <= fix_result(rem_sel, dbz, ovf, qneg, rneg, q, r[N-1:0], dvd_raw);
            done   <= 1'b1;
            busy   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases, protocol timing,
// ignored start, back-to-back, async reset abort and randomized operations.
module tb_seq_divider;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] result;

   int n_vec = 0;
   int n_err = 0;

   seq_divider #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   // Architectural RISC-V semantics using plain 64-bit arithmetic.
   function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
      longint sa, sb, qq, rr;
      if (b == '0) return o[1] ? a : {N{1'b1}};
      if (o[0]) return o[1] ? (a % b) : (a / b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      return o[1] ? rr[N-1:0] : qq[N-1:0];
   endfunction

   function automatic logic [N-1:0] pick_operand();
      logic [N-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = $urandom;
         1:       v = '0;
         2:       v = {N{1'b1}};
         3:       v = 32'h8000_0000;
         4:       v = N'($urandom_range(0, 20));
         default: v = -N'($urandom_range(1, 20));
      endcase
      return v;
   endfunction

   // Issues one op and waits (bounded) for done; lat = edges from accept to done.
   task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] res, output int lat);
      @(negedge clk);
      op = o; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      res = 'x;
      for (int e = 1; e <= N + 6; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = e;
            res = result;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [1:0]   o;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] exp;
   } vec_t;

   task automatic test_directed();
      vec_t tbl[$];
      logic [N-1:0] res;
      int lat;
      tbl.push_back('{2'b01, 32'd100,        32'd7,          32'd14});
      tbl.push_back('{2'b11, 32'd100,        32'd7,          32'd2});
      tbl.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
      tbl.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
      tbl.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1});
      tbl.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
      tbl.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
      tbl.push_back('{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF});
      tbl.push_back('{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678});
      tbl.push_back('{2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF});
      tbl.push_back('{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB});
      tbl.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD});
      foreach (tbl[i]) begin
         run_op(tbl[i].o, tbl[i].a, tbl[i].b, res, lat);
         n_vec++;
         if (res !== tbl[i].exp || lat != N + 1) begin
            n_err++;
            $display("FAIL directed[%0d] op=%b %h/%h: result=%h lat=%0d, required %h lat=%0d",
                     i, tbl[i].o, tbl[i].a, tbl[i].b, res, lat, tbl[i].exp, N + 1);
         end
      end
   endtask

   task automatic test_timing();
      @(negedge clk);
      op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL timing_accept: busy=%b done=%b, required 1 0", busy, done);
      end
      for (int e = 1; e <= N; e++) begin
         @(posedge clk);
         #1;
         n_vec++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL timing_iter%0d: busy=%b done=%b, required 1 0", e, busy, done);
         end
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b1 || result !== 32'd14) begin
         n_err++;
         $display("FAIL timing_done: busy=%b done=%b result=%0d, required 0 1 14", busy, done, result);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
         n_err++;
         $display("FAIL timing_after: busy=%b done=%b result=%0d, required 0 0 14", busy, done, result);
      end
   endtask

   task automatic test_back_to_back();
      int lat = -1;
      @(negedge clk);
      op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int e = 1; e <= N + 6; e++) begin
         if (e == 4) begin
            @(negedge clk);
            op = 2'b00; dividend = 32'd99; divisor = 32'd9; start = 1'b1;
         end
         @(posedge clk);
         #1;
         if (e == 4) start = 1'b0;
         if (done) begin
            lat = e;
            break;
         end
      end
      n_vec++;
      if (lat != N + 1 || result !== 32'd10) begin
         n_err++;
         $display("FAIL ignore_start: result=%0d lat=%0d, required 10 lat=%0d", result, lat, N + 1);
      end
      // Still inside the done cycle: issue the next request now.
      op = 2'b01; dividend = 32'd81; divisor = 32'd9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
      end
      lat = -1;
      for (int e = 1; e <= N + 6; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = e;
            break;
         end
      end
      n_vec++;
      if (lat != N + 1 || result !== 32'd9) begin
         n_err++;
         $display("FAIL b2b_result: result=%0d lat=%0d, required 9 lat=%0d", result, lat, N + 1);
      end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      logic [N-1:0] res;
      int lat;
      @(negedge clk);
      op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         n_err++;
         $display("FAIL reset_async: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int e = 0; e < N + 6; e++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      n_vec++;
      if (dones != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_abort: done pulses=%0d busy=%b, required 0 0", dones, busy);
      end
      run_op(2'b01, 32'd9, 32'd3, res, lat);
      n_vec++;
      if (res !== 32'd3 || lat != N + 1) begin
         n_err++;
         $display("FAIL reset_recover: result=%0d lat=%0d, required 3 lat=%0d", res, lat, N + 1);
      end
   endtask

   task automatic test_random();
      logic [1:0]   o;
      logic [N-1:0] a, b, res, exp;
      int lat;
      for (int i = 0; i < 300; i++) begin
         o = 2'($urandom_range(0, 3));
         a = pick_operand();
         b = pick_operand();
         exp = model(o, a, b);
         run_op(o, a, b, res, lat);
         n_vec++;
         if (res !== exp || lat != N + 1) begin
            n_err++;
            $display("FAIL random[%0d] op=%b %h/%h: result=%h lat=%0d, required %h lat=%0d",
                     i, o, a, b, res, lat, exp, N + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
